// File: rtl/popcount_pkg.sv
// Shared constants and types for the popcount harness blocks.
// Holds vector/count widths, the coprime stride table and the generator FSM states.
package popcount_pkg;

    localparam int POP_N  = 25;
    localparam int POP_CW = 5;

    // Every entry is coprime to 25, so a full walk visits all positions.
    localparam logic [4:0] STRIDE_TAB [20] = '{
        5'd1,  5'd2,  5'd3,  5'd4,  5'd6,
        5'd7,  5'd8,  5'd9,  5'd11, 5'd12,
        5'd13, 5'd14, 5'd16, 5'd17, 5'd18,
        5'd19, 5'd21, 5'd22, 5'd23, 5'd24
    };

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        HOLD
    } ug_state_t;

endpackage

// File: rtl/popcount_lfsr16.sv
// 16-bit Galois LFSR, x^16+x^14+x^13+x^11+1, advancing once per step.
// Only compiled when UNARY_GEN_LFSR_EN is defined.
`ifdef UNARY_GEN_LFSR_EN
module popcount_lfsr16 (
    input  logic        clk,
    input  logic        rst,
    input  logic        step,
    input  logic [15:0] seed,
    output logic [15:0] q
);

    logic [15:0] r_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= seed;
        end else if (step) begin
            r_q <= {1'b0, r_q[15:1]} ^ (r_q[0] ? 16'hB400 : 16'h0000);
        end
    end

    assign q = r_q;

endmodule
`endif

// File: rtl/popcount25_unary_gen.sv
// Builds a 25-bit vector holding exactly count_in ones, one bit per cycle.
// UNARY_GEN_LFSR_EN scatters positions via LFSR; otherwise a thermometer code.
module popcount25_unary_gen
    import popcount_pkg::*;
#(
    parameter int          N    = POP_N,
    parameter int          CW   = POP_CW,
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          count_valid,
    output logic          count_ready,
    input  logic [CW-1:0] count_in,
    output logic          vec_valid,
    input  logic          vec_ready,
    output logic [N-1:0]  vec_out,
    output logic [CW-1:0] vec_count
);

    if (SEED == 16'h0000) begin : g_bad_seed
        $error("SEED must be non-zero");
    end

    ug_state_t     r_state;
    ug_state_t     w_next;
    logic          r_rst_d;
    logic [N-1:0]  r_vec;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] r_rem;
    logic [CW-1:0] w_n;
    logic [4:0]    r_pos;
    logic [4:0]    r_stride;
    logic [4:0]    w_start;
    logic [4:0]    w_stride;
    logic [5:0]    w_sum;
    logic          w_accept;

    // r_rst_d keeps count_ready low for the cycle following a reset edge.
    assign count_ready = (r_state == IDLE) && !r_rst_d;
    assign vec_valid   = (r_state == HOLD);
    assign vec_out     = r_vec;
    assign vec_count   = r_cnt;

    assign w_accept = count_ready && count_valid;
    assign w_n      = (count_in > CW'(N)) ? CW'(N) : count_in;
    assign w_sum    = {1'b0, r_pos} + {1'b0, r_stride};

`ifdef UNARY_GEN_LFSR_EN
    logic [15:0] w_lfsr;
    logic [4:0]  w_idx;
    logic        w_unused_lfsr;

    popcount_lfsr16 u_lfsr (
        .clk  (clk),
        .rst  (rst),
        .step (w_accept),
        .seed (SEED),
        .q    (w_lfsr)
    );

    assign w_start = (w_lfsr[4:0] >= 5'd25) ? w_lfsr[4:0] - 5'd25
                                            : w_lfsr[4:0];
    assign w_idx   = (w_lfsr[12:8] >= 5'd20) ? w_lfsr[12:8] - 5'd20
                                             : w_lfsr[12:8];
    assign w_stride = STRIDE_TAB[w_idx];
    assign w_unused_lfsr = ^{w_lfsr[15:13], w_lfsr[7:5]};
`else
    assign w_start  = 5'd0;
    assign w_stride = 5'd1;
`endif

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: if (w_accept) w_next = (w_n == '0) ? HOLD : FILL;
            FILL: if (r_rem == CW'(1)) w_next = HOLD;
            HOLD: if (vec_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_rst_d  <= 1'b1;
            r_vec    <= '0;
            r_cnt    <= '0;
            r_rem    <= '0;
            r_pos    <= 5'd0;
            r_stride <= 5'd1;
        end else begin
            r_state <= w_next;
            r_rst_d <= 1'b0;
            if (w_accept) begin
                r_vec    <= '0;
                r_cnt    <= w_n;
                r_rem    <= w_n;
                r_pos    <= w_start;
                r_stride <= w_stride;
            end else if (r_state == FILL) begin
                r_vec[r_pos] <= 1'b1;
                // pos + stride < 50, so one conditional subtract wraps it
                r_pos <= (w_sum >= 6'd25) ? 5'(w_sum - 6'd25) : w_sum[4:0];
                r_rem <= r_rem - CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_popcount25_unary_gen.sv
// Scoreboard bench for popcount25_unary_gen, valid in both builds.
// Exact thermometer vectors are checked only when UNARY_GEN_LFSR_EN is undefined.
module tb_popcount25_unary_gen;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        count_valid = 1'b0;
    logic        count_ready;
    logic [4:0]  count_in = 5'd0;
    logic        vec_valid;
    logic        vec_ready = 1'b0;
    logic [24:0] vec_out;
    logic [4:0]  vec_count;

    int checks = 0;
    int failures = 0;
    int exp_q[$];

    popcount25_unary_gen dut (
        .clk         (clk),
        .rst         (rst),
        .count_valid (count_valid),
        .count_ready (count_ready),
        .count_in    (count_in),
        .vec_valid   (vec_valid),
        .vec_ready   (vec_ready),
        .vec_out     (vec_out),
        .vec_count   (vec_count)
    );

    always #5 clk = ~clk;

    function automatic int popcnt(input logic [24:0] v);
        int c = 0;
        for (int i = 0; i < 25; i++) c += int'(v[i]);
        return c;
    endfunction

    function automatic logic [24:0] therm(input int n);
        logic [24:0] one = 25'd1;
        return (one << n) - 25'd1;
    endfunction

    task automatic send(input int cnt, output bit ok);
        int guard = 0;
        while (!count_ready && guard < 60) begin
            @(posedge clk); #1;
            guard++;
        end
        ok = count_ready;
        if (ok) begin
            count_in = 5'(cnt);
            count_valid = 1'b1;
            exp_q.push_back(cnt > 25 ? 25 : cnt);
            @(posedge clk); #1;
            count_valid = 1'b0;
        end
    endtask

    // lat counts edges from the accept edge (that edge is 1) to vec_valid
    task automatic wait_valid(output int lat, output bit ok);
        lat = 1;
        while (!vec_valid && lat < 60) begin
            @(posedge clk); #1;
            lat++;
        end
        ok = vec_valid;
    endtask

    task automatic handshake(input bit rnd, output bit ok);
        bit hs = 1'b0;
        for (int i = 0; i < 60 && !hs; i++) begin
            vec_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            hs = vec_ready && vec_valid;
            @(posedge clk); #1;
        end
        vec_ready = 1'b0;
        ok = hs;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (vec_valid !== 1'b0) begin
            failures++;
            $display("FAIL rst_vec_valid got=%0b exp=0", vec_valid);
        end
        checks++;
        if (count_ready !== 1'b0) begin
            failures++;
            $display("FAIL rst_count_ready got=%0b exp=0", count_ready);
        end
        checks++;
        if (vec_out !== 25'h0) begin
            failures++;
            $display("FAIL rst_vec_out got=%h exp=0", vec_out);
        end
        checks++;
        if (vec_count !== 5'd0) begin
            failures++;
            $display("FAIL rst_vec_count got=%0d exp=0", vec_count);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (count_ready !== 1'b1) begin
            failures++;
            $display("FAIL rst_release_ready got=%0b exp=1", count_ready);
        end
    endtask

    task automatic test_thermo3();
        bit ok;
        int lat;
        int n;
        vec_ready = 1'b1;
        send(3, ok);
        wait_valid(lat, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL c3_valid_timeout got=0 exp=1");
        end
        n = (exp_q.size() != 0) ? exp_q.pop_front() : -1;
        checks++;
        if (lat !== 4) begin
            failures++;
            $display("FAIL c3_latency got=%0d exp=4", lat);
        end
`ifndef UNARY_GEN_LFSR_EN
        checks++;
        if (vec_out !== 25'h0000007) begin
            failures++;
            $display("FAIL c3_vec_out got=%h exp=0000007", vec_out);
        end
`else
        checks++;
        if (popcnt(vec_out) !== n) begin
            failures++;
            $display("FAIL c3_popcount got=%0d exp=%0d", popcnt(vec_out), n);
        end
`endif
        checks++;
        if (vec_count !== 5'(n)) begin
            failures++;
            $display("FAIL c3_vec_count got=%0d exp=%0d", vec_count, n);
        end
        handshake(1'b0, ok);
        checks++;
        if (count_ready !== 1'b1) begin
            failures++;
            $display("FAIL c3_ready_after got=%0b exp=1", count_ready);
        end
    endtask

    task automatic test_count0_31();
        bit ok;
        int lat;
        int n;
        send(0, ok);
        wait_valid(lat, ok);
        n = (exp_q.size() != 0) ? exp_q.pop_front() : -1;
        checks++;
        if (lat !== 1) begin
            failures++;
            $display("FAIL c0_latency got=%0d exp=1", lat);
        end
        checks++;
        if (vec_out !== 25'h0) begin
            failures++;
            $display("FAIL c0_vec_out got=%h exp=0", vec_out);
        end
        checks++;
        if (vec_count !== 5'(n)) begin
            failures++;
            $display("FAIL c0_vec_count got=%0d exp=%0d", vec_count, n);
        end
        handshake(1'b0, ok);
        send(31, ok);
        wait_valid(lat, ok);
        n = (exp_q.size() != 0) ? exp_q.pop_front() : -1;
        checks++;
        if (lat !== 26) begin
            failures++;
            $display("FAIL c31_latency got=%0d exp=26", lat);
        end
        checks++;
        if (vec_count !== 5'd25 || n != 25) begin
            failures++;
            $display("FAIL c31_vec_count got=%0d exp=25", vec_count);
        end
        checks++;
        if (vec_out !== 25'h1FFFFFF) begin
            failures++;
            $display("FAIL c31_vec_out got=%h exp=1ffffff", vec_out);
        end
        handshake(1'b0, ok);
    endtask

    task automatic test_backpressure();
        bit ok;
        int lat;
        int n;
        logic [24:0] snap;
        vec_ready = 1'b0;
        send(7, ok);
        wait_valid(lat, ok);
        n = (exp_q.size() != 0) ? exp_q.pop_front() : -1;
        snap = vec_out;
        checks++;
        if (popcnt(snap) !== n) begin
            failures++;
            $display("FAIL bp_popcount got=%0d exp=%0d", popcnt(snap), n);
        end
`ifndef UNARY_GEN_LFSR_EN
        checks++;
        if (snap !== therm(n)) begin
            failures++;
            $display("FAIL bp_thermo got=%h exp=%h", snap, therm(n));
        end
`endif
        for (int i = 0; i < 10; i++) begin
            count_valid = 1'($urandom_range(0, 1));
            count_in = 5'($urandom_range(0, 31));
            @(posedge clk); #1;
            checks++;
            if (vec_out !== snap || vec_count !== 5'(n)) begin
                failures++;
                $display("FAIL bp_stable got=%h/%0d exp=%h/%0d",
                         vec_out, vec_count, snap, n);
            end
            checks++;
            if (count_ready !== 1'b0 || vec_valid !== 1'b1) begin
                failures++;
                $display("FAIL bp_flags got=rdy%0b/vld%0b exp=rdy0/vld1",
                         count_ready, vec_valid);
            end
        end
        count_valid = 1'b0;
        handshake(1'b0, ok);
        checks++;
        if (count_ready !== 1'b1 || vec_valid !== 1'b0) begin
            failures++;
            $display("FAIL bp_release got=rdy%0b/vld%0b exp=rdy1/vld0",
                     count_ready, vec_valid);
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (vec_valid !== 1'b0 || count_ready !== 1'b1) begin
            failures++;
            $display("FAIL bp_no_extra got=vld%0b/rdy%0b exp=vld0/rdy1",
                     vec_valid, count_ready);
        end
    endtask

    task automatic test_reset_mid_fill();
        bit ok;
        vec_ready = 1'b0;
        send(20, ok);
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        exp_q.delete();
        checks++;
        if (vec_out !== 25'h0 || vec_count !== 5'd0) begin
            failures++;
            $display("FAIL rmf_vec got=%h/%0d exp=0/0", vec_out, vec_count);
        end
        checks++;
        if (vec_valid !== 1'b0 || count_ready !== 1'b0) begin
            failures++;
            $display("FAIL rmf_flags got=vld%0b/rdy%0b exp=vld0/rdy0",
                     vec_valid, count_ready);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (count_ready !== 1'b1) begin
            failures++;
            $display("FAIL rmf_ready got=%0b exp=1", count_ready);
        end
    endtask

    task automatic test_random();
        bit ok;
        int lat;
        int n;
        int cnt;
        logic [24:0] cov = '0;
        for (int it = 0; it < 2000; it++) begin
            cnt = int'($urandom_range(0, 31));
            send(cnt, ok);
            if (ok) wait_valid(lat, ok);
            if (!ok) begin
                checks++;
                failures++;
                $display("FAIL rnd_timeout got=stall exp=progress it=%0d", it);
                break;
            end
            n = (exp_q.size() != 0) ? exp_q.pop_front() : -1;
            checks++;
            if (lat !== n + 1) begin
                failures++;
                $display("FAIL rnd_latency got=%0d exp=%0d", lat, n + 1);
            end
            checks++;
            if (popcnt(vec_out) !== n) begin
                failures++;
                $display("FAIL rnd_popcount got=%0d exp=%0d vec=%h",
                         popcnt(vec_out), n, vec_out);
            end
            checks++;
            if (vec_count !== 5'(n)) begin
                failures++;
                $display("FAIL rnd_vec_count got=%0d exp=%0d", vec_count, n);
            end
            checks++;
            if (popcnt(vec_out) !== int'(vec_count)) begin
                failures++;
                $display("FAIL rnd_golden got=%0d exp=%0d",
                         vec_count, popcnt(vec_out));
            end
`ifndef UNARY_GEN_LFSR_EN
            checks++;
            if (vec_out !== therm(n)) begin
                failures++;
                $display("FAIL rnd_thermo got=%h exp=%h", vec_out, therm(n));
            end
`endif
            cov |= vec_out;
            handshake(1'b1, ok);
            if (!ok) begin
                checks++;
                failures++;
                $display("FAIL rnd_hs_timeout got=stall exp=accept it=%0d", it);
                break;
            end
        end
        checks++;
        if (cov !== 25'h1FFFFFF) begin
            failures++;
            $display("FAIL rnd_coverage got=%h exp=1ffffff", cov);
        end
    endtask

    initial begin
        test_reset();
        test_thermo3();
        test_count0_31();
        test_backpressure();
        test_reset_mid_fill();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
